// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for ring_counter_n.
// The helpers work on a MAX_W-bit vector with the active width passed in.
// Callers zero-extend into the helper and truncate the result back to WIDTH.
package ring_counter_pkg;

  localparam int MAX_W = 64;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // Ring seed is 0...01 and Johnson seed is all zeros.
  // The width argument only guards against a degenerate zero width.
  function automatic logic [MAX_W-1:0] seed_of(input logic mode, input int width);
    logic [MAX_W-1:0] s;
    s = '0;
    if (mode == MODE_RING && width > 0) s[0] = 1'b1;
    return s;
  endfunction

  // One shift step. Johnson mode inverts the bit that wraps around; ring mode does not.
  // Bits at and above width come back as zero.
  function automatic logic [MAX_W-1:0] next_of(input logic [MAX_W-1:0] q,
                                              input logic mode,
                                              input logic dir,
                                              input int width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] hi;
    logic             wrap_bit;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    hi   = q >> (width - 1);
    if (dir == DIR_UP) begin
      wrap_bit = (mode == MODE_JOHNSON) ? ~hi[0] : hi[0];
      r        = ((q << 1) & mask) | MAX_W'(wrap_bit);
    end else begin
      wrap_bit = (mode == MODE_JOHNSON) ? ~q[0] : q[0];
      r        = (q >> 1) | (MAX_W'(wrap_bit) << (width - 1));
    end
    return r & mask;
  endfunction

endpackage

// File: rtl/ring_counter_legal_chk.sv
// Combinational legality check for a ring or Johnson counter value.
// Ring: exactly one bit set.
// Johnson: at most one 0/1 boundary between adjacent bits. That covers all-zero,
// all-one, and a single run of ones anchored at bit 0 or at bit WIDTH-1.
module ring_counter_legal_chk
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic             legal
);

  int ones_cnt;
  int edge_cnt;

  // Count set bits and adjacent-bit transitions, then judge by mode.
  always_comb begin
    ones_cnt = 0;
    edge_cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) ones_cnt = ones_cnt + 1;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (value[i] != value[i+1]) edge_cnt = edge_cnt + 1;
    end
    legal = (mode == MODE_JOHNSON) ? (edge_cnt <= 1) : (ones_cnt == 1);
  end

endmodule

// File: rtl/ring_counter_n.sv
// Parametrised ring / Johnson counter with runtime mode and direction,
// parallel load and a wrap pulse. WIDTH must be at least 2.
// Define RING_COUNTER_SELFCHECK_EN to build the legality checker. With it,
// an illegal q or load_val is replaced by the seed and err pulses. Without it,
// err is tied low.
module ring_counter_n
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] seed_cur;
  logic [WIDTH-1:0] seed_new;
  logic [WIDTH-1:0] step_val;

  assign seed_cur = WIDTH'(seed_of(mode_q, WIDTH));
  assign seed_new = WIDTH'(seed_of(mode, WIDTH));
  assign step_val = WIDTH'(next_of(MAX_W'(q_q), mode_q, dir, WIDTH));

`ifdef RING_COUNTER_SELFCHECK_EN
  logic q_legal;
  logic load_legal;
  logic err_q, err_d;

  ring_counter_legal_chk #(.WIDTH(WIDTH)) u_chk_q (
    .value (q_q),
    .mode  (mode_q),
    .legal (q_legal)
  );

  ring_counter_legal_chk #(.WIDTH(WIDTH)) u_chk_load (
    .value (load_val),
    .mode  (mode_q),
    .legal (load_legal)
  );
`endif

  // Next state, highest priority first: mode change, recovery, load, step, hold.
  always_comb begin
    mode_d = mode_q;
    q_d    = q_q;
    wrap_d = 1'b0;
`ifdef RING_COUNTER_SELFCHECK_EN
    err_d  = 1'b0;
`endif
    if (mode != mode_q) begin
      mode_d = mode;
      q_d    = seed_new;
    end
`ifdef RING_COUNTER_SELFCHECK_EN
    else if (!q_legal) begin
      q_d   = seed_cur;
      err_d = 1'b1;
    end else if (load) begin
      if (load_legal) begin
        q_d = load_val;
      end else begin
        q_d   = seed_cur;
        err_d = 1'b1;
      end
    end
`else
    else if (load) begin
      q_d = load_val;
    end
`endif
    else if (en) begin
      q_d    = step_val;
      wrap_d = (step_val == seed_cur);
    end
  end

  // State registers; reset lands in ring mode at the ring seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
      mode_q <= MODE_RING;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef RING_COUNTER_SELFCHECK_EN
  // Error pulse register, reset alongside the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_n.sv
// Self-checking bench for ring_counter_n at WIDTH = 4. It runs the directed
// scenarios first, then a randomized run checked against a sequence-level model.
module tb_ring_counter_n;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         dir;
  logic         mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         wrap;
  logic         err;

  int checks   = 0;
  int failures = 0;

  // Model state.
  logic [W-1:0] m_q;
  logic         m_mode;
  logic         m_wrap;
  logic         m_err;

`ifdef RING_COUNTER_SELFCHECK_EN
  localparam bit SELFCHECK = 1'b1;
`else
  localparam bit SELFCHECK = 1'b0;
`endif

  ring_counter_n #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Johnson state k steps up from all-zero: k ones filling from the bottom,
  // then the ones drain away from the bottom.
  function automatic logic [W-1:0] johnson_at(input int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = MASK & ~((1 << (k - W)) - 1);
    return W'(v);
  endfunction

  function automatic logic [W-1:0] m_seed(input logic md);
    return md ? W'(0) : W'(1);
  endfunction

  function automatic bit m_legal(input logic [W-1:0] v, input logic md);
    if (!md) return $countones(v) == 1;
    for (int k = 0; k < 2 * W; k++) if (v == johnson_at(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_step(input logic [W-1:0] v, input logic md, input logic dn);
    int x;
    int r;
    x = int'(v);
    if (!dn) begin
      if (!md) r = ((x * 2) | (x >> (W - 1))) & MASK;
      else     r = ((x * 2) & MASK) | (((x >> (W - 1)) & 1) ^ 1);
    end else begin
      if (!md) r = (x >> 1) | ((x & 1) << (W - 1));
      else     r = (x >> 1) | (((x & 1) ^ 1) << (W - 1));
    end
    return W'(r);
  endfunction

  task automatic model_reset();
    m_q    = W'(1);
    m_mode = 1'b0;
    m_wrap = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (mode != m_mode) begin
      m_mode = mode;
      m_q    = m_seed(mode);
    end else if (SELFCHECK && !m_legal(m_q, m_mode)) begin
      m_q   = m_seed(m_mode);
      m_err = 1'b1;
    end else if (load) begin
      if (SELFCHECK && !m_legal(load_val, m_mode)) begin
        m_q   = m_seed(m_mode);
        m_err = 1'b1;
      end else begin
        m_q = load_val;
      end
    end else if (en) begin
      m_q    = m_step(m_q, m_mode, dir);
      m_wrap = (m_q == m_seed(m_mode));
    end
  endtask

  // Advance model and DUT one edge; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    #12;
    checks++;
    if (q !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%b wrap=%b err=%b required q=0001 wrap=0 err=0", q, wrap, err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ring_up();
    logic [W-1:0] exp_q [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                4'b0010, 4'b0100, 4'b1000, 4'b0001};
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (q !== exp_q[i] || wrap !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL ring_up[%0d]: q=%b wrap=%b required q=%b wrap=%b",
                 i, q, wrap, exp_q[i], (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_johnson_up();
    logic [W-1:0] exp_q [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
    mode = 1'b1; en = 1'b0; dir = 1'b0;
    cycle();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL johnson_seed: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (q !== exp_q[i] || wrap !== (i == 7)) begin
        failures++;
        $display("FAIL johnson_up[%0d]: q=%b wrap=%b required q=%b wrap=%b",
                 i, q, wrap, exp_q[i], (i == 7));
      end
    end
  endtask

  task automatic test_dir_hold();
    logic [W-1:0] exp_q [7] = '{4'b0001, 4'b1000, 4'b0100, 4'b0100,
                                4'b0100, 4'b0100, 4'b1000};
    logic         exp_en [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         exp_dr [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en  = exp_en[i];
      dir = exp_dr[i];
      cycle();
      checks++;
      if (q !== exp_q[i] || wrap !== 1'b0) begin
        failures++;
        $display("FAIL dir_hold[%0d]: q=%b wrap=%b required q=%b wrap=0", i, q, wrap, exp_q[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] exp_q;
    logic         exp_err;
    en = 1'b0; dir = 1'b0; load = 1'b1; load_val = 4'b0100;
    cycle();
    checks++;
    if (q !== 4'b0100 || err !== 1'b0) begin
      failures++;
      $display("FAIL load_legal: q=%b err=%b required q=0100 err=0", q, err);
    end
    load_val = 4'b0110;
    cycle();
    exp_q   = SELFCHECK ? 4'b0001 : 4'b0110;
    exp_err = SELFCHECK;
    checks++;
    if (q !== exp_q || err !== exp_err) begin
      failures++;
      $display("FAIL load_illegal: q=%b err=%b required q=%b err=%b", q, err, exp_q, exp_err);
    end
    load = 1'b0;
    cycle();
    checks++;
    if (q !== exp_q || err !== 1'b0) begin
      failures++;
      $display("FAIL load_after: q=%b err=%b required q=%b err=0", q, err, exp_q);
    end
    // A load of the seed must not raise wrap, even with en asserted.
    load = 1'b1; en = 1'b1; load_val = 4'b0001;
    cycle();
    checks++;
    if (q !== 4'b0001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_seed: q=%b wrap=%b required q=0001 wrap=0", q, wrap);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_mode_switch();
    load = 1'b1; load_val = 4'b0100; en = 1'b0;
    cycle();
    mode = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'b0011;
    cycle();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mode_switch: q=%b wrap=%b err=%b required q=0000 wrap=0 err=0", q, wrap, err);
    end
    load = 1'b0;
    cycle();
    checks++;
    if (q !== 4'b0001) begin
      failures++;
      $display("FAIL mode_switch_step: q=%b required q=0001", q);
    end
  endtask

  task automatic test_async_reset();
    // A Johnson down step from 0001 returns to the seed, so wrap is high here.
    dir = 1'b1; en = 1'b1;
    cycle();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL johnson_down_wrap: q=%b wrap=%b required q=0000 wrap=1", q, wrap);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (q !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: q=%b wrap=%b err=%b required q=0001 wrap=0 err=0", q, wrap, err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_johnson: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) mode = ~mode;
      en   = ($urandom_range(3) != 0);
      dir  = $urandom_range(1);
      load = ($urandom_range(7) == 0);
      case ($urandom_range(2))
        0:       load_val = W'(1 << $urandom_range(W - 1));
        1:       load_val = johnson_at($urandom_range(2 * W - 1));
        default: load_val = W'($urandom_range(MASK));
      endcase
      cycle();
      checks++;
      if (q !== m_q || wrap !== m_wrap || err !== m_err) begin
        failures++;
        $display("FAIL random[%0d]: q=%b wrap=%b err=%b required q=%b wrap=%b err=%b",
                 i, q, wrap, err, m_q, m_wrap, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_up();
    test_johnson_up();
    test_dir_hold();
    test_load();
    test_mode_switch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_counter_n.md
# ring_counter_n

Parametrised ring/Johnson counter with runtime-selectable mode and direction, parallel load, wrap pulse and optional illegal-state recovery. Next generation of the fixed 4-bit one-hot ring counter. Used as a one-hot phase sequencer and a Johnson divide-by-2N timing generator in level-0 control paths. All outputs are registered.

## Interface
- WIDTH, 4, counter width in bits; must be at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance one step on this edge.
- dir  input  1  0 = shift toward MSB (up), 1 = shift toward LSB (down).
- mode  input  1  0 = ring (one-hot, period WIDTH), 1 = Johnson (period 2*WIDTH).
- load  input  1  parallel load request.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  counter state.
- wrap  output  1  one-cycle pulse on the edge where a step returns q to the seed.
- err  output  1  one-cycle pulse on illegal-state recovery; tied 0 without the macro.

## Operation
- Seed values: ring = 0…01; Johnson = 0…00.
- Internal register mode_q holds the active mode.
- Ring up: q <= {q[W-2:0], q[W-1]}. Ring down: q <= {q[0], q[W-1:1]}.
- Johnson up: q <= {q[W-2:0], ~q[W-1]}. Johnson down: q <= {~q[0], q[W-1:1]}.
- Priority per edge, highest first:
  - mode != mode_q: q <= seed(mode) and mode_q <= mode. en and load are ignored; wrap = 0.
  - With the macro, current q illegal for mode_q: q <= seed and err = 1.
  - load = 1: q <= load_val. With the macro, an illegal load_val gives q <= seed and err = 1.
  - en = 1: step by dir. wrap = 1 if the new q equals the seed.
  - Otherwise q holds.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: the 1s form one contiguous run touching bit 0 or bit W-1, or q is all-0.
- dir may change on any cycle. The next step uses the new direction with no bubble.
- A load that sets q to the seed does not raise wrap.

## Timing
- Reset (asynchronous, takes effect immediately): q = 0…01, mode_q = 0, wrap = 0, err = 0.
- If mode = 1 when reset releases, the first edge switches to the Johnson seed.
- q, wrap and err update together on the same edge. Latency from inputs to outputs is one cycle.
- wrap and err are 1-cycle pulses. If conditions persist they re-assert each qualifying edge.
- Reset asserted mid-sequence aborts the sequence. No pending state survives reset.

## Configuration
- RING_COUNTER_SELFCHECK_EN defined:
  - A legality checker runs on q and on load_val.
  - Illegal values are replaced by the seed and pulse err.
  - Recovers from SEU or forced states within one edge.
- RING_COUNTER_SELFCHECK_EN undefined:
  - No checker is built and err is constant 0.
  - load_val is loaded verbatim and illegal states propagate through the shift rules.

## Structure
- Package ring_counter_pkg contains:
  - MODE_RING/MODE_JOHNSON and DIR_UP/DIR_DOWN constants.
  - Seed function seed_of(mode, WIDTH).
  - Next-state function next_of(q, mode, dir).
- Sub-module ring_counter_legal_chk: combinational, parametrised by WIDTH. Inputs are value and mode; output is legal. It is instantiated twice (on q and on load_val) and only under the macro.

## Test plan
All scenarios use WIDTH = 4.
- Ring up: reset, then mode = 0, dir = 0, en = 1 for 8 edges. Required q: 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001. wrap pulses on the 4th and 8th edges.
- Johnson up: mode = 1, one edge gives q = 0000. Then en = 1 for 8 edges. Required q: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap pulses only on the 8th.
- Direction and hold: ring from 0001, dir = 1, en = 1 gives 1000, 0100. Then en = 0 for 3 edges holds 0100. Then dir = 0 gives 1000.
- Load: ring load 0100 gives q = 0100 with err = 0. Load 0110:
  - with the macro: q = 0001, err = 1 for one cycle;
  - without the macro: q = 0110.
- Mode switch: at q = 0100 in ring with en = 1 and load = 1, toggle mode. Required: q = 0000, wrap = 0, load ignored. The next en edge gives 0001.
- Async reset: assert rst_n = 0 between edges mid-Johnson sequence. Required: q = 0001, wrap = 0 and err = 0 immediately, before the next clk edge.
